// File: rtl/cdb_result_queue.sv
// cdb_result_queue
// Small in-order result FIFO between the FU result selector and the CDB.
// Accepts at most one selected FU result per cycle and acks that FU slot.
// It drains at most one entry per cycle while the CDB consumer is ready.
// A squash empties the queue at the next edge.
// CDB outputs come from the head entry with no same-cycle bypass.
// An accepted result is therefore visible on the CDB one cycle later at the earliest.

module cdb_result_queue #(
    parameter int DEPTH    = 4,
    parameter int FU_SIZE  = 20,
    parameter int FU_NUM_W = 6,
    parameter int TAG_W    = 6,
    parameter int VAL_W    = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                squash,
    input  logic                in_valid,
    input  logic [FU_NUM_W-1:0] in_fu_num,
    input  logic [3:0]          in_cat,
    input  logic [TAG_W-1:0]    in_tag,
    input  logic [VAL_W-1:0]    in_value,
    output logic [FU_SIZE-1:0]  fu_ack,
    output logic                full,
    input  logic                cdb_ready,
    output logic                cdb_valid,
    output logic [TAG_W-1:0]    cdb_tag,
    output logic [VAL_W-1:0]    cdb_value,
    output logic                cdb_is_branch
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]    DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [FU_NUM_W-1:0] FU_LIMIT = FU_NUM_W'(FU_SIZE);

    // Pointer and occupancy state
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Entry storage.  It is never cleared, because validity is tracked by count_q alone.
    logic [TAG_W-1:0] tag_mem_q [DEPTH];
    logic [VAL_W-1:0] val_mem_q [DEPTH];
    logic             br_mem_q  [DEPTH];

    logic fu_num_ok_s;
    logic push_s;
    logic pop_s;

    // Only the branch bit of the category travels with the result.
    logic unused_cat_s;
    assign unused_cat_s = ^in_cat[2:0];

    // Status flags and head-entry view driven straight from registered state
    always_comb begin
        cdb_valid     = (count_q != {CNT_W{1'b0}});
        full          = (count_q == DEPTH_C);
        cdb_tag       = tag_mem_q[head_q];
        cdb_value     = val_mem_q[head_q];
        cdb_is_branch = br_mem_q[head_q];
    end

    // Handshake decode.  Squash dominates everything.
    // Push is also masked while reset is held, so no ack leaks out during reset.
    // A full queue accepts a push only when the head leaves in the same cycle.
    always_comb begin
        fu_num_ok_s = (in_fu_num < FU_LIMIT);
        pop_s       = cdb_valid && cdb_ready && !squash;
        push_s      = !reset && in_valid && !squash && fu_num_ok_s && (!full || pop_s);
    end

    // One-hot acknowledge of the accepted FU slot
    always_comb begin
        fu_ack = {FU_SIZE{1'b0}};
        for (int i = 0; i < FU_SIZE; i++) begin
            fu_ack[i] = push_s && (in_fu_num == FU_NUM_W'(i));
        end
    end

    // Next-state computation for pointers and occupancy
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (squash) begin
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                tail_d = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Write the accepted result into the tail slot
    always_ff @(posedge clock) begin
        if (push_s) begin
            tag_mem_q[tail_q] <= in_tag;
            val_mem_q[tail_q] <= in_value;
            br_mem_q[tail_q]  <= in_cat[3];
        end
    end

endmodule

// File: tb/tb_cdb_result_queue.sv
// Self-checking bench for cdb_result_queue.
// Directed scenarios use hand-derived expected values.
// A randomized phase compares the DUT against a queue-based reference model.

module tb_cdb_result_queue;

    logic        clock;
    logic        reset;
    logic        squash;
    logic        in_valid;
    logic [5:0]  in_fu_num;
    logic [3:0]  in_cat;
    logic [5:0]  in_tag;
    logic [31:0] in_value;
    logic [19:0] fu_ack;
    logic        full;
    logic        cdb_ready;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        cdb_is_branch;

    int n_vec;
    int n_miss;

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] val;
        logic        br;
    } ent_t;

    cdb_result_queue dut (
        .clock        (clock),
        .reset        (reset),
        .squash       (squash),
        .in_valid     (in_valid),
        .in_fu_num    (in_fu_num),
        .in_cat       (in_cat),
        .in_tag       (in_tag),
        .in_value     (in_value),
        .fu_ack       (fu_ack),
        .full         (full),
        .cdb_ready    (cdb_ready),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_value    (cdb_value),
        .cdb_is_branch(cdb_is_branch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] fu, input logic [3:0] cat,
                         input logic [5:0] tag, input logic [31:0] val);
        in_valid  = v;
        in_fu_num = fu;
        in_cat    = cat;
        in_tag    = tag;
        in_value  = val;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        n_vec++;
        if (cdb_valid !== 1'b0 || full !== 1'b0 || fu_ack !== 20'h00000) begin
            n_miss++;
            $display("FAIL reset_hold: valid=%b full=%b ack=%h expected 0 0 00000", cdb_valid, full, fu_ack);
        end
        reset = 1'b0;
        cdb_ready = 1'b0;
        drive(1'b1, 6'd0, 4'b0001, 6'd1, 32'h1);
        tick();
        drive(1'b1, 6'd1, 4'b0001, 6'd2, 32'h2);
        tick();
        drive(1'b1, 6'd2, 4'b0001, 6'd3, 32'h3);
        #1;
        n_vec++;
        if (cdb_valid !== 1'b1 || fu_ack !== 20'h00004) begin
            n_miss++;
            $display("FAIL reset_pre: valid=%b ack=%h expected 1 00004", cdb_valid, fu_ack);
        end
        #1;
        reset = 1'b1;
        #1;
        n_vec++;
        if (cdb_valid !== 1'b0 || full !== 1'b0 || fu_ack !== 20'h00000) begin
            n_miss++;
            $display("FAIL reset_async: valid=%b full=%b ack=%h expected 0 0 00000", cdb_valid, full, fu_ack);
        end
        tick();
        reset = 1'b0;
        drive(1'b0, 6'd0, 4'b0000, 6'd0, 32'h0);
        #4;
        n_vec++;
        if (cdb_valid !== 1'b0 || full !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_after: valid=%b full=%b expected 0 0", cdb_valid, full);
        end
        tick();
    endtask

    task automatic test_pass_through();
        cdb_ready = 1'b1;
        drive(1'b1, 6'd3, 4'b0001, 6'd5, 32'h0000DEAD);
        #4;
        n_vec++;
        if (fu_ack !== 20'h00008 || cdb_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL pass_ack: ack=%h valid=%b expected 00008 0", fu_ack, cdb_valid);
        end
        tick();
        drive(1'b0, 6'd0, 4'b0000, 6'd0, 32'h0);
        #4;
        n_vec++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 6'd5 || cdb_value !== 32'h0000DEAD || cdb_is_branch !== 1'b0) begin
            n_miss++;
            $display("FAIL pass_out: valid=%b tag=%0d val=%h br=%b expected 1 5 0000dead 0",
                     cdb_valid, cdb_tag, cdb_value, cdb_is_branch);
        end
        tick();
        #4;
        n_vec++;
        if (cdb_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL pass_drain: valid=%b expected 0", cdb_valid);
        end
        tick();
    endtask

    task automatic test_fill();
        logic [19:0] exp_ack;
        cdb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 6'(i), 4'b0001, 6'(i), 32'(i) + 32'h100);
            #4;
            exp_ack = (i < 4) ? (20'd1 << i) : 20'd0;
            n_vec++;
            if (fu_ack !== exp_ack || full !== (i == 4)) begin
                n_miss++;
                $display("FAIL fill_push%0d: ack=%h full=%b expected %h %b", i, fu_ack, full, exp_ack, (i == 4));
            end
            tick();
        end
        drive(1'b0, 6'd0, 4'b0000, 6'd0, 32'h0);
        cdb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #4;
            n_vec++;
            if (cdb_valid !== 1'b1 || cdb_tag !== 6'(i) || cdb_value !== 32'(i) + 32'h100) begin
                n_miss++;
                $display("FAIL fill_drain%0d: valid=%b tag=%0d val=%h expected 1 %0d %h",
                         i, cdb_valid, cdb_tag, cdb_value, i, 32'(i) + 32'h100);
            end
            tick();
        end
        #4;
        n_vec++;
        if (cdb_valid !== 1'b0 || full !== 1'b0) begin
            n_miss++;
            $display("FAIL fill_empty: valid=%b full=%b expected 0 0", cdb_valid, full);
        end
        tick();
    endtask

    task automatic test_full_push_pop();
        cdb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 6'(i), 4'b0010, 6'(10 + i), 32'hA000 + 32'(i));
            tick();
        end
        cdb_ready = 1'b1;
        drive(1'b1, 6'd16, 4'b1000, 6'd14, 32'hBEEF0014);
        #4;
        n_vec++;
        if (fu_ack !== 20'h10000 || full !== 1'b1 || cdb_tag !== 6'd10) begin
            n_miss++;
            $display("FAIL full_pp_ack: ack=%h full=%b tag=%0d expected 10000 1 10", fu_ack, full, cdb_tag);
        end
        tick();
        drive(1'b0, 6'd0, 4'b0000, 6'd0, 32'h0);
        cdb_ready = 1'b0;
        #4;
        n_vec++;
        if (full !== 1'b1 || cdb_tag !== 6'd11) begin
            n_miss++;
            $display("FAIL full_pp_count: full=%b tag=%0d expected 1 11", full, cdb_tag);
        end
        tick();
        cdb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #4;
            n_vec++;
            if (cdb_valid !== 1'b1 || cdb_tag !== 6'(11 + i) || cdb_is_branch !== (i == 3)) begin
                n_miss++;
                $display("FAIL full_pp_drain%0d: valid=%b tag=%0d br=%b expected 1 %0d %b",
                         i, cdb_valid, cdb_tag, cdb_is_branch, 11 + i, (i == 3));
            end
            if (i == 3) begin
                n_vec++;
                if (cdb_value !== 32'hBEEF0014) begin
                    n_miss++;
                    $display("FAIL full_pp_value: val=%h expected beef0014", cdb_value);
                end
            end
            tick();
        end
    endtask

    task automatic test_squash();
        cdb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 6'(i), 4'b0001, 6'(20 + i), 32'(i));
            tick();
        end
        squash = 1'b1;
        cdb_ready = 1'b1;
        drive(1'b1, 6'd5, 4'b0001, 6'd30, 32'h30);
        #4;
        n_vec++;
        if (fu_ack !== 20'h00000) begin
            n_miss++;
            $display("FAIL squash_ack: ack=%h expected 00000", fu_ack);
        end
        tick();
        squash = 1'b0;
        drive(1'b0, 6'd0, 4'b0000, 6'd0, 32'h0);
        #4;
        n_vec++;
        if (cdb_valid !== 1'b0 || full !== 1'b0) begin
            n_miss++;
            $display("FAIL squash_empty: valid=%b full=%b expected 0 0", cdb_valid, full);
        end
        tick();
        drive(1'b1, 6'd7, 4'b0001, 6'd33, 32'h33);
        #4;
        n_vec++;
        if (fu_ack !== 20'h00080 || cdb_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL squash_repush: ack=%h valid=%b expected 00080 0", fu_ack, cdb_valid);
        end
        tick();
        drive(1'b0, 6'd0, 4'b0000, 6'd0, 32'h0);
        #4;
        n_vec++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 6'd33) begin
            n_miss++;
            $display("FAIL squash_after: valid=%b tag=%0d expected 1 33", cdb_valid, cdb_tag);
        end
        tick();
    endtask

    task automatic test_illegal_index();
        cdb_ready = 1'b0;
        drive(1'b1, 6'd19, 4'b0001, 6'd40, 32'h40);
        #4;
        n_vec++;
        if (fu_ack !== 20'h80000) begin
            n_miss++;
            $display("FAIL illegal_fu19: ack=%h expected 80000", fu_ack);
        end
        tick();
        drive(1'b1, 6'd25, 4'b0001, 6'd41, 32'h41);
        #4;
        n_vec++;
        if (fu_ack !== 20'h00000) begin
            n_miss++;
            $display("FAIL illegal_fu25: ack=%h expected 00000", fu_ack);
        end
        tick();
        drive(1'b1, 6'd20, 4'b0001, 6'd42, 32'h42);
        #4;
        n_vec++;
        if (fu_ack !== 20'h00000) begin
            n_miss++;
            $display("FAIL illegal_fu20: ack=%h expected 00000", fu_ack);
        end
        tick();
        drive(1'b0, 6'd0, 4'b0000, 6'd0, 32'h0);
        cdb_ready = 1'b1;
        #4;
        n_vec++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 6'd40) begin
            n_miss++;
            $display("FAIL illegal_head: valid=%b tag=%0d expected 1 40", cdb_valid, cdb_tag);
        end
        tick();
        #4;
        n_vec++;
        if (cdb_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL illegal_count: valid=%b expected 0", cdb_valid);
        end
        tick();
    endtask

    task automatic test_random();
        ent_t        q[$];
        ent_t        e;
        logic        exp_full;
        logic        exp_pop;
        logic        exp_push;
        logic [19:0] one;
        logic [19:0] exp_ack;
        one = 20'd1;
        drive(1'b0, 6'd0, 4'b0000, 6'd0, 32'h0);
        squash = 1'b1;
        tick();
        squash = 1'b0;
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 9) < 7), 6'($urandom_range(0, 23)),
                  4'b0001 << $urandom_range(0, 3), 6'($urandom), 32'($urandom));
            cdb_ready = ($urandom_range(0, 9) < 6);
            squash    = ($urandom_range(0, 19) == 0);
            #4;
            exp_full = (q.size() == 4);
            exp_pop  = (q.size() != 0) && cdb_ready && !squash;
            exp_push = in_valid && !squash && (in_fu_num < 6'd20) && (!exp_full || exp_pop);
            exp_ack  = exp_push ? (one << in_fu_num) : 20'd0;
            n_vec++;
            if (fu_ack !== exp_ack || full !== exp_full || cdb_valid !== (q.size() != 0)) begin
                n_miss++;
                $display("FAIL rand_ctl c=%0d: ack=%h full=%b valid=%b expected %h %b %b",
                         c, fu_ack, full, cdb_valid, exp_ack, exp_full, (q.size() != 0));
            end
            if (q.size() != 0) begin
                n_vec++;
                if (cdb_tag !== q[0].tag || cdb_value !== q[0].val || cdb_is_branch !== q[0].br) begin
                    n_miss++;
                    $display("FAIL rand_data c=%0d: tag=%h val=%h br=%b expected %h %h %b",
                             c, cdb_tag, cdb_value, cdb_is_branch, q[0].tag, q[0].val, q[0].br);
                end
            end
            e.tag = in_tag;
            e.val = in_value;
            e.br  = in_cat[3];
            tick();
            if (squash) begin
                q.delete();
            end else begin
                if (exp_pop) void'(q.pop_front());
                if (exp_push) q.push_back(e);
            end
        end
        squash    = 1'b0;
        cdb_ready = 1'b0;
        drive(1'b0, 6'd0, 4'b0000, 6'd0, 32'h0);
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        reset     = 1'b1;
        squash    = 1'b0;
        cdb_ready = 1'b0;
        drive(1'b0, 6'd0, 4'b0000, 6'd0, 32'h0);
        test_reset();
        test_pass_through();
        test_fill();
        test_full_push_pop();
        test_squash();
        test_illegal_index();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
